// File: rtl/change_dispenser.sv
// Greedy change dispenser: pays an amount using coins of 10/5/2/1 from per-denomination
// stock counters, spacing coin-eject pulses GAP+1 cycles apart.
module change_dispenser #(
    parameter int unsigned GAP        = 4,
    parameter logic [7:0]  INIT_STOCK = 8'd10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [7:0] amount,
    input  logic       refill,
    input  logic [3:0] refill_sel,
    output logic [3:0] coin_out,
    output logic       busy,
    output logic       done,
    output logic       short,
    output logic [7:0] remaining,
    output logic [7:0] stock1,
    output logic [7:0] stock2,
    output logic [7:0] stock5,
    output logic [7:0] stock10
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHOOSE,
        S_EMIT,
        S_WAIT,
        S_FINISH
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(GAP - 1);
    localparam bit         GAP_ONE   = (GAP == 1);

    state_t     state_q, state_d;
    logic [7:0] remaining_q, remaining_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] sel_q, sel_d;
    logic [7:0] stock1_q, stock1_d;
    logic [7:0] stock2_q, stock2_d;
    logic [7:0] stock5_q, stock5_d;
    logic [7:0] stock10_q, stock10_d;
    logic [7:0] rem_after_coin;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [7:0] coin_value(input logic [3:0] sel);
        case (sel)
            4'b0001: return 8'd1;
            4'b0010: return 8'd2;
            4'b0100: return 8'd5;
            4'b1000: return 8'd10;
            default: return 8'd0;
        endcase
    endfunction

    always_comb begin
        state_d        = state_q;
        remaining_d    = remaining_q;
        cnt_d          = cnt_q;
        sel_d          = sel_q;
        stock1_d       = stock1_q;
        stock2_d       = stock2_q;
        stock5_d       = stock5_q;
        stock10_d      = stock10_q;
        rem_after_coin = remaining_q - coin_value(sel_q);

        case (state_q)
            S_IDLE: begin
                if (refill) begin
                    if (refill_sel[0]) stock1_d  = sat_inc(stock1_q);
                    if (refill_sel[1]) stock2_d  = sat_inc(stock2_q);
                    if (refill_sel[2]) stock5_d  = sat_inc(stock5_q);
                    if (refill_sel[3]) stock10_d = sat_inc(stock10_q);
                end
                if (req) begin
                    remaining_d = amount;
                    state_d     = (amount == 8'd0) ? S_FINISH : S_CHOOSE;
                end
            end
            S_CHOOSE: begin
                // Largest coin that fits and is in stock; none left means a short payout.
                if (remaining_q >= 8'd10 && stock10_q != 8'd0)     sel_d = 4'b1000;
                else if (remaining_q >= 8'd5 && stock5_q != 8'd0)  sel_d = 4'b0100;
                else if (remaining_q >= 8'd2 && stock2_q != 8'd0)  sel_d = 4'b0010;
                else if (remaining_q >= 8'd1 && stock1_q != 8'd0)  sel_d = 4'b0001;
                else                                               sel_d = 4'b0000;
                state_d = (sel_d != 4'b0000) ? S_EMIT : S_FINISH;
            end
            S_EMIT: begin
                remaining_d = rem_after_coin;
                if (sel_q[0]) stock1_d  = stock1_q - 8'd1;
                if (sel_q[1]) stock2_d  = stock2_q - 8'd1;
                if (sel_q[2]) stock5_d  = stock5_q - 8'd1;
                if (sel_q[3]) stock10_d = stock10_q - 8'd1;
                if (GAP_ONE || rem_after_coin == 8'd0) begin
                    state_d = S_CHOOSE;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = WAIT_LOAD;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = S_CHOOSE;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            remaining_q <= 8'd0;
            cnt_q       <= 4'd0;
            sel_q       <= 4'd0;
            stock1_q    <= INIT_STOCK;
            stock2_q    <= INIT_STOCK;
            stock5_q    <= INIT_STOCK;
            stock10_q   <= INIT_STOCK;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            stock1_q    <= stock1_d;
            stock2_q    <= stock2_d;
            stock5_q    <= stock5_d;
            stock10_q   <= stock10_d;
        end
    end

    assign coin_out  = (state_q == S_EMIT) ? sel_q : 4'b0000;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FINISH);
    assign short     = (state_q == S_FINISH) && (remaining_q != 8'd0);
    assign remaining = remaining_q;
    assign stock1    = stock1_q;
    assign stock2    = stock2_q;
    assign stock5    = stock5_q;
    assign stock10   = stock10_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser (GAP=4, INIT_STOCK=10).
module tb_change_dispenser;

    localparam int GAP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req = 1'b0;
    logic [7:0] amount = 8'd0;
    logic       refill = 1'b0;
    logic [3:0] refill_sel = 4'd0;
    logic [3:0] coin_out;
    logic       busy, done, short;
    logic [7:0] remaining, stock1, stock2, stock5, stock10;

    int tests = 0;
    int fails = 0;

    change_dispenser #(.GAP(GAP), .INIT_STOCK(8'd10)) dut (
        .clk(clk), .rst(rst), .req(req), .amount(amount),
        .refill(refill), .refill_sel(refill_sel),
        .coin_out(coin_out), .busy(busy), .done(done), .short(short),
        .remaining(remaining), .stock1(stock1), .stock2(stock2),
        .stock5(stock5), .stock10(stock10)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_stocks(input string tag, input logic [7:0] s1, input logic [7:0] s2,
                                input logic [7:0] s5, input logic [7:0] s10);
        check({tag, "_stock1"}, stock1, s1);
        check({tag, "_stock2"}, stock2, s2);
        check({tag, "_stock5"}, stock5, s5);
        check({tag, "_stock10"}, stock10, s10);
    endtask

    task automatic start_req(input logic [7:0] amt);
        req    = 1'b1;
        amount = amt;
        tick();
        req    = 1'b0;
    endtask

    // first=1: coin due on the next edge; otherwise GAP quiet cycles precede it
    task automatic next_coin(input string tag, input logic [3:0] exp, input bit first);
        if (!first) begin
            for (int i = 0; i < GAP; i++) begin
                tick();
                check({tag, "_gap"}, coin_out, 4'd0);
            end
        end
        tick();
        check({tag, "_coin"}, coin_out, exp);
    endtask

    task automatic finish_req(input string tag, input logic exp_short, input logic [7:0] exp_rem);
        tick();
        check({tag, "_done_early"}, done, 1'b0);
        tick();
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_short"}, short, exp_short);
        check({tag, "_rem"}, remaining, exp_rem);
        tick();
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic single_coin(input string tag, input logic [7:0] amt, input logic [3:0] coin);
        start_req(amt);
        next_coin(tag, coin, 1'b1);
        finish_req(tag, 1'b0, 8'd0);
    endtask

    initial begin
        // reset state
        tick();
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_short", short, 1'b0);
        check("rst_coin", coin_out, 4'd0);
        check("rst_rem", remaining, 8'd0);
        check_stocks("rst", 8'd10, 8'd10, 8'd10, 8'd10);
        rst = 1'b1;
        tick();

        // amount 18 from full stock: 10, 5, 2, 1
        start_req(8'd18);
        check("a18_busy", busy, 1'b1);
        check("a18_choose_coin", coin_out, 4'd0);
        next_coin("a18_c10", 4'b1000, 1'b1);
        next_coin("a18_c5", 4'b0100, 1'b0);
        next_coin("a18_c2", 4'b0010, 1'b0);
        next_coin("a18_c1", 4'b0001, 1'b0);
        finish_req("a18", 1'b0, 8'd0);
        check_stocks("a18", 8'd9, 8'd9, 8'd9, 8'd9);

        // empty the 5s after a fresh reset, then pay 8 with 2s
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_stocks("rst2", 8'd10, 8'd10, 8'd10, 8'd10);
        for (int i = 0; i < 10; i++) single_coin("drain5", 8'd5, 4'b0100);
        check("drain5_stock5", stock5, 8'd0);
        start_req(8'd8);
        next_coin("a8_c2a", 4'b0010, 1'b1);
        next_coin("a8_c2b", 4'b0010, 1'b0);
        next_coin("a8_c2c", 4'b0010, 1'b0);
        next_coin("a8_c2d", 4'b0010, 1'b0);
        finish_req("a8", 1'b0, 8'd0);
        check_stocks("a8", 8'd10, 8'd6, 8'd0, 8'd10);

        // empty 1s and 2s, then amount 3 cannot be paid at all
        for (int i = 0; i < 6; i++) single_coin("drain2", 8'd2, 4'b0010);
        for (int i = 0; i < 10; i++) single_coin("drain1", 8'd1, 4'b0001);
        check_stocks("drained", 8'd0, 8'd0, 8'd0, 8'd10);
        start_req(8'd3);
        check("a3_choose_coin", coin_out, 4'd0);
        check("a3_choose_done", done, 1'b0);
        tick();
        check("a3_done", done, 1'b1);
        check("a3_short", short, 1'b1);
        check("a3_rem", remaining, 8'd3);
        check("a3_coin", coin_out, 4'd0);
        tick();
        check("a3_idle", busy, 1'b0);
        check("a3_rem_hold", remaining, 8'd3);
        check("a3_short_pulse", short, 1'b0);

        // amount 0: done right after accept, busy for one cycle
        start_req(8'd0);
        check("a0_done", done, 1'b1);
        check("a0_busy", busy, 1'b1);
        check("a0_short", short, 1'b0);
        check("a0_rem", remaining, 8'd0);
        tick();
        check("a0_idle", busy, 1'b0);
        check("a0_done_pulse", done, 1'b0);

        // refill in IDLE, then refill together with req
        refill = 1'b1;
        refill_sel = 4'b0011;
        tick();
        refill = 1'b0;
        check_stocks("refill", 8'd1, 8'd1, 8'd0, 8'd10);
        refill = 1'b1;
        refill_sel = 4'b0001;
        req = 1'b1;
        amount = 8'd1;
        tick();
        refill = 1'b0;
        req = 1'b0;
        check("refreq_stock1", stock1, 8'd2);
        check("refreq_busy", busy, 1'b1);
        next_coin("refreq_c1", 4'b0001, 1'b1);
        finish_req("refreq", 1'b0, 8'd0);
        check("refreq_stock1_after", stock1, 8'd1);

        // req/refill held high while busy are ignored
        start_req(8'd12);
        req = 1'b1;
        amount = 8'd50;
        refill = 1'b1;
        refill_sel = 4'b1111;
        next_coin("a12_c10", 4'b1000, 1'b1);
        next_coin("a12_c2", 4'b0010, 1'b0);
        req = 1'b0;
        refill = 1'b0;
        finish_req("a12", 1'b0, 8'd0);
        check_stocks("a12", 8'd1, 8'd0, 8'd0, 8'd9);

        // saturation of stock10
        refill = 1'b1;
        refill_sel = 4'b1000;
        for (int i = 0; i < 250; i++) tick();
        refill = 1'b0;
        check_stocks("sat", 8'd1, 8'd0, 8'd0, 8'd255);

        // reset between the first and second coin of amount 15
        start_req(8'd15);
        next_coin("a15_c10", 4'b1000, 1'b1);
        tick();
        tick();
        check("a15_wait_busy", busy, 1'b1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("a15_rst_busy", busy, 1'b0);
        check("a15_rst_coin", coin_out, 4'd0);
        check("a15_rst_done", done, 1'b0);
        check("a15_rst_short", short, 1'b0);
        check("a15_rst_rem", remaining, 8'd0);
        check_stocks("a15_rst", 8'd10, 8'd10, 8'd10, 8'd10);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("a15_no_coin", coin_out, 4'd0);
            check("a15_stay_idle", busy, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
